pe_id_config_loader: RTL and testbench
======================================

PE_ID_CONFIG_LOADER -- requirements
Module: pe_id_config_loader

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  one-cycle request to program the whole PE array; honoured only in IDLE.
REQ-004 abort  input  1  returns to IDLE next cycle; no done pulse.
REQ-005 pe_h  input  3  active PE rows; sampled on accepted start; values >6 clamp to 6.
REQ-006 pe_w  input  4  active PE columns; sampled on accepted start; values >8 clamp to 8.
REQ-007 ln_config_in  input  5  LN config word from ID generator.
REQ-008 id_net  output  2  generator lookup select: 0 filter, 1 ifmap, 2 ipsum, 3 opsum.
REQ-009 id_is_x  output  1  lookup select: 1 XID table, 0 YID table.
REQ-010 id_idx  output  6  lookup index: row for YID, row*pe_w+col for XID.
REQ-011 id_xid_in  input  5  generator XID at (id_net, id_idx).
REQ-012 id_yid_in  input  3  generator YID at (id_net, id_idx).
REQ-013 cfg_valid  output  1  config write offered.
REQ-014 cfg_ready  input  1  PE array accepts the write.
REQ-015 cfg_kind  output  2  0 YID, 1 XID, 2 LN config.
REQ-016 cfg_net  output  2  target network, equal to id_net.
REQ-017 cfg_addr  output  6  target row or PE index, equal to id_idx.
REQ-018 cfg_data  output  5  payload: XID, zero-extended YID, or LN config.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse after the final accepted write.

Function
REQ-021 States: IDLE, LN, YID, XID, DONE; transitions occur only on clk.
REQ-022 IDLE->LN on start; latch the clamped pe_h and pe_w; net=0, idx=0.
REQ-023 LN: cfg_valid=1, cfg_kind=2, cfg_data=ln_config_in; on handshake go to YID with net=0.
REQ-024 YID: idx 0..pe_h-1; each handshake increments idx; after idx pe_h-1 go to XID with idx=0.
REQ-025 XID: idx 0..pe_h*pe_w-1; after the last index go to YID with net+1, or to DONE if net was 3.
REQ-026 If pe_h or pe_w is 0, skip all YID and XID phases: LN->DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Handshake: transfer occurs when cfg_valid and cfg_ready are high on the same edge.
REQ-029 While cfg_valid=1 and cfg_ready=0, the state, idx, net and all cfg_* outputs stay stable.
REQ-030 cfg_data is driven combinationally from the id_*_in inputs; the generator inputs must stay constant while busy.
REQ-031 Lookup timing: id_net, id_is_x and id_idx are registered, and the combinational lookup is valid in the same cycle.
REQ-032 With cfg_ready held high, one write per cycle; total valid cycles = 1 + 4*(pe_h + pe_h*pe_w).
REQ-033 start while busy is ignored.
REQ-034 abort has priority over start and over a handshake in the same cycle; a write accepted on that edge is void.
REQ-035 cfg_valid is 0 in IDLE and DONE.

Reset
REQ-036 Reset gives: state IDLE; busy, done and cfg_valid 0; all other outputs and latched values 0.
REQ-037 Reset asserted mid-sequence discards progress; after release, no write occurs until a new start.

Configuration
REQ-038 Macro ID_SKIP_DISABLED_EN.
  - Defined: any XID entry equal to 31 or YID entry equal to 7 is not offered. That index takes one cycle with cfg_valid=0. Receivers reset their IDs to all-ones.
  - Undefined: every entry is offered, and REQ-032 holds exactly.

Verification
REQ-039 pe_h=6, pe_w=8, cfg_ready=1, start -> 217 valid cycles, then a done pulse; write order is LN, then Y then X for nets 0,1,2,3.
REQ-040 cfg_ready toggles every cycle during an XID phase -> each index accepted exactly once; payload stable while stalled.
REQ-041 pe_w=0 -> a single LN write (cfg_data=ln_config_in, e.g. 27), then done; no YID or XID writes.
REQ-042 abort asserted at XID idx 10 of net 1 -> IDLE next cycle; no done; a new start restarts at LN.
REQ-043 start pulsed while busy, and rst_n pulled low at net 2 -> start ignored; after reset, outputs are 0 and no writes occur.
REQ-044 ID_SKIP_DISABLED_EN defined, opsum table with 40 of 48 XIDs equal to 31 -> only 8 opsum XID writes occur, and cfg_valid=0 on the skipped cycles.

Source files
------------

// File: rtl/pe_id_config_loader_if.sv
// Configuration-write bus between the PE ID config loader (master) and the PE array (slave).
interface pe_id_config_loader_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_kind;
  logic [1:0] cfg_net;
  logic [5:0] cfg_addr;
  logic [4:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_kind,
    output cfg_net,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_kind,
    input  cfg_net,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/pe_id_config_loader.sv
// Walks the ID generator tables and programs LN config, then YID/XID for all four networks.
// Optional macro ID_SKIP_DISABLED_EN: entries holding the all-ones "disabled" ID are not written.
module pe_id_config_loader (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [2:0]                    pe_h,
  input  logic [3:0]                    pe_w,
  input  logic [4:0]                    ln_config_in,
  output logic [1:0]                    id_net,
  output logic                          id_is_x,
  output logic [5:0]                    id_idx,
  input  logic [4:0]                    id_xid_in,
  input  logic [2:0]                    id_yid_in,
  pe_id_config_loader_if.master         cfg,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LN,
    S_YID,
    S_XID,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] net, net_nxt;
  logic [5:0] idx, idx_nxt;
  logic [2:0] rows, rows_nxt;
  logic [3:0] cols, cols_nxt;

  logic       skip;
  logic       offer;
  logic       advance;
  logic [5:0] pe_count;
  logic       last_y;
  logic       last_x;

`ifdef ID_SKIP_DISABLED_EN
  // Receivers already reset to all-ones, so those entries cost one idle cycle instead of a write.
  assign skip = ((state == S_XID) && (id_xid_in == 5'h1f)) ||
                ((state == S_YID) && (id_yid_in == 3'h7));
`else
  assign skip = 1'b0;
`endif

  assign offer    = (state == S_LN) || (((state == S_YID) || (state == S_XID)) && !skip);
  assign advance  = (offer && cfg.cfg_ready) || skip;
  assign pe_count = 6'(rows) * 6'(cols);
  assign last_y   = (idx == (6'(rows) - 6'd1));
  assign last_x   = (idx == (pe_count - 6'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      net   <= 2'd0;
      idx   <= 6'd0;
      rows  <= 3'd0;
      cols  <= 4'd0;
    end else begin
      state <= state_nxt;
      net   <= net_nxt;
      idx   <= idx_nxt;
      rows  <= rows_nxt;
      cols  <= cols_nxt;
    end
  end

  // Abort wins over everything, including a handshake on the same edge.
  always_comb begin
    state_nxt = state;
    net_nxt   = net;
    idx_nxt   = idx;
    rows_nxt  = rows;
    cols_nxt  = cols;
    if (abort) begin
      state_nxt = S_IDLE;
      net_nxt   = 2'd0;
      idx_nxt   = 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_LN;
            net_nxt   = 2'd0;
            idx_nxt   = 6'd0;
            rows_nxt  = (pe_h > 3'd6) ? 3'd6 : pe_h;
            cols_nxt  = (pe_w > 4'd8) ? 4'd8 : pe_w;
          end
        end
        S_LN: begin
          if (advance) begin
            state_nxt = ((rows == 3'd0) || (cols == 4'd0)) ? S_DONE : S_YID;
            net_nxt   = 2'd0;
            idx_nxt   = 6'd0;
          end
        end
        S_YID: begin
          if (advance) begin
            if (last_y) begin
              state_nxt = S_XID;
              idx_nxt   = 6'd0;
            end else begin
              idx_nxt = idx + 6'd1;
            end
          end
        end
        S_XID: begin
          if (advance) begin
            if (last_x) begin
              idx_nxt = 6'd0;
              if (net == 2'd3) begin
                state_nxt = S_DONE;
                net_nxt   = 2'd0;
              end else begin
                state_nxt = S_YID;
                net_nxt   = net + 2'd1;
              end
            end else begin
              idx_nxt = idx + 6'd1;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          net_nxt   = 2'd0;
          idx_nxt   = 6'd0;
        end
        default: begin
          state_nxt = S_IDLE;
          net_nxt   = 2'd0;
          idx_nxt   = 6'd0;
        end
      endcase
    end
  end

  // Lookup select comes straight from registers; payload follows the generator combinationally.
  always_comb begin
    id_net        = net;
    id_idx        = idx;
    id_is_x       = (state == S_XID);
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    cfg.cfg_valid = offer;
    cfg.cfg_net   = net;
    cfg.cfg_addr  = idx;
    cfg.cfg_kind  = 2'd0;
    cfg.cfg_data  = 5'd0;
    case (state)
      S_LN: begin
        cfg.cfg_kind = 2'd2;
        cfg.cfg_data = ln_config_in;
      end
      S_YID: begin
        cfg.cfg_kind = 2'd0;
        cfg.cfg_data = {2'b00, id_yid_in};
      end
      S_XID: begin
        cfg.cfg_kind = 2'd1;
        cfg.cfg_data = id_xid_in;
      end
      default: begin
        cfg.cfg_kind = 2'd0;
        cfg.cfg_data = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_id_config_loader.sv
// Scoreboard bench for pe_id_config_loader: expected writes are queued at start and popped on each handshake.
module tb_pe_id_config_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [2:0] pe_h;
  logic [3:0] pe_w;
  logic [4:0] ln_config_in;
  logic [1:0] id_net;
  logic       id_is_x;
  logic [5:0] id_idx;
  logic [4:0] id_xid_in;
  logic [2:0] id_yid_in;
  logic       busy;
  logic       done;

  pe_id_config_loader_if cfg_bus ();

  pe_id_config_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .pe_h         (pe_h),
    .pe_w         (pe_w),
    .ln_config_in (ln_config_in),
    .id_net       (id_net),
    .id_is_x      (id_is_x),
    .id_idx       (id_idx),
    .id_xid_in    (id_xid_in),
    .id_yid_in    (id_yid_in),
    .cfg          (cfg_bus),
    .busy         (busy),
    .done         (done)
  );

  int          errors = 0;
  int          checks = 0;
  logic [14:0] exp_q[$];
  int          exp_total;
  int          writes_count;
  int          valid_cycles;
  int          done_count;
  int          opsum_x_writes;
  bit          xid31_mode;
  bit          stalled;
  logic [14:0] held;
  logic [14:0] got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gen_xid(input int n, input int i);
    if (xid31_mode && n == 3 && i >= 8) return 5'd31;
    return 5'((n * 7 + i * 3 + 1) % 31);
  endfunction

  function automatic logic [2:0] gen_yid(input int n, input int r);
    return 3'((n + r) % 7);
  endfunction

  function automatic bit is_skipped(input bit is_x, input logic [4:0] x, input logic [2:0] y);
`ifdef ID_SKIP_DISABLED_EN
    return is_x ? (x == 5'd31) : (y == 3'd7);
`else
    return 1'b0;
`endif
  endfunction

  // Generator model: table lookup driven by the DUT's registered select.
  always_comb begin
    id_xid_in = gen_xid(int'(id_net), int'(id_idx));
    id_yid_in = gen_yid(int'(id_net), int'(id_idx));
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      got = {cfg_bus.cfg_kind, cfg_bus.cfg_net, cfg_bus.cfg_addr, cfg_bus.cfg_data};
      if (stalled) begin
        checkOutput("stall_valid", 32'(cfg_bus.cfg_valid), 32'd1);
        checkOutput("stall_payload", 32'(got), 32'(held));
      end
      if (cfg_bus.cfg_valid && cfg_bus.cfg_ready && !abort) begin
        writes_count++;
        if (cfg_bus.cfg_kind == 2'd1 && cfg_bus.cfg_net == 2'd3) opsum_x_writes++;
        if (exp_q.size() == 0) checkOutput("extra_write", 32'(got), 32'h7fff_ffff);
        else checkOutput("write", 32'(got), 32'(exp_q.pop_front()));
      end
      stalled = cfg_bus.cfg_valid && !cfg_bus.cfg_ready && !abort;
      held    = got;
      if (cfg_bus.cfg_valid) valid_cycles++;
      if (done) done_count++;
    end
  end

  task automatic applyStimulus(input int h, input int w, input logic [4:0] ln);
    int ch;
    int cw;
    logic [4:0] x;
    logic [2:0] y;
    ch = (h > 6) ? 6 : h;
    cw = (w > 8) ? 8 : w;
    exp_q.delete();
    exp_q.push_back({2'd2, 2'd0, 6'd0, ln});
    if (ch != 0 && cw != 0) begin
      for (int n = 0; n < 4; n++) begin
        for (int r = 0; r < ch; r++) begin
          y = gen_yid(n, r);
          if (!is_skipped(1'b0, 5'd0, y)) exp_q.push_back({2'd0, 2'(n), 6'(r), {2'b00, y}});
        end
        for (int i = 0; i < ch * cw; i++) begin
          x = gen_xid(n, i);
          if (!is_skipped(1'b1, x, 3'd0)) exp_q.push_back({2'd1, 2'(n), 6'(i), x});
        end
      end
    end
    exp_total      = exp_q.size();
    writes_count   = 0;
    valid_cycles   = 0;
    done_count     = 0;
    opsum_x_writes = 0;
    @(posedge clk); #1;
    start        = 1'b1;
    pe_h         = 3'(h);
    pe_w         = 4'(w);
    ln_config_in = ln;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggles each cycle, 2: random ready.
  task automatic waitDone(input int max_cycles, input int mode);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       cfg_bus.cfg_ready = 1'b1;
        1:       cfg_bus.cfg_ready = ~cfg_bus.cfg_ready;
        default: cfg_bus.cfg_ready = 1'($urandom_range(0, 1));
      endcase
      if (done_count > 0) begin
        seen = 1'b1;
        break;
      end
    end
    cfg_bus.cfg_ready = 1'b1;
    checkOutput("done_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("done_pulses", 32'(done_count), 32'd1);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("writes_total", 32'(writes_count), 32'(exp_total));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    rst_n             = 1'b1;
    start             = 1'b0;
    abort             = 1'b0;
    pe_h              = 3'd0;
    pe_w              = 4'd0;
    ln_config_in      = 5'd0;
    cfg_bus.cfg_ready = 1'b0;
    xid31_mode        = 1'b0;
    writes_count      = 0;
    valid_cycles      = 0;
    done_count        = 0;
    opsum_x_writes    = 0;
    #2 rst_n = 1'b0;
    #10;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(cfg_bus.cfg_valid), 32'd0);
    checkOutput("rst_id_net", 32'(id_net), 32'd0);
    checkOutput("rst_id_is_x", 32'(id_is_x), 32'd0);
    checkOutput("rst_id_idx", 32'(id_idx), 32'd0);
    checkOutput("rst_kind", 32'(cfg_bus.cfg_kind), 32'd0);
    checkOutput("rst_addr", 32'(cfg_bus.cfg_addr), 32'd0);
    checkOutput("rst_data", 32'(cfg_bus.cfg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_bus.cfg_ready = 1'b1;

    // Full 6x8 array with ready held high.
    applyStimulus(6, 8, 5'd19);
    waitDone(400, 0);
    checkOutput("full_valid_cycles", 32'(valid_cycles), 32'd217);

    // Oversized dimensions clamp to 6x8; ready toggles to exercise stalls.
    applyStimulus(7, 15, 5'd3);
    waitDone(1000, 1);

    // Zero width: LN only.
    applyStimulus(6, 0, 5'd27);
    waitDone(20, 0);
    checkOutput("ln_only_valid", 32'(valid_cycles), 32'd1);

    // Small array with random backpressure.
    applyStimulus(2, 3, 5'd9);
    waitDone(400, 2);

    // Abort at XID idx 10 of net 1.
    cfg_bus.cfg_ready = 1'b1;
    applyStimulus(4, 4, 5'd5);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (id_is_x && id_net == 2'd1 && id_idx == 6'd10) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("abort_reached", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(cfg_bus.cfg_valid), 32'd0);
    checkOutput("abort_writes", 32'(writes_count), 32'd35);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_count), 32'd0);
    applyStimulus(1, 1, 5'd7);
    waitDone(50, 0);

    // Start while busy is ignored; reset at net 2 discards progress.
    applyStimulus(3, 3, 5'd21);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    pe_h  = 3'd1;
    pe_w  = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (id_net == 2'd2) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("net2_reached", 32'(found), 32'd1);
    checkOutput("net2_writes", 32'(writes_count), 32'd25);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(cfg_bus.cfg_valid), 32'd0);
    checkOutput("mid_rst_id_net", 32'(id_net), 32'd0);
    checkOutput("mid_rst_data", 32'(cfg_bus.cfg_data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_writes", 32'(writes_count), 32'd25);
    checkOutput("post_rst_done", 32'(done_count), 32'd0);

    // Opsum table with 40 of 48 XIDs at all-ones.
    xid31_mode = 1'b1;
    applyStimulus(6, 8, 5'd11);
    waitDone(400, 0);
    checkOutput("opsum_valid_cycles", 32'(valid_cycles), 32'(exp_total));
`ifdef ID_SKIP_DISABLED_EN
    checkOutput("opsum_x_writes", 32'(opsum_x_writes), 32'd8);
`else
    checkOutput("opsum_x_writes", 32'(opsum_x_writes), 32'd48);
`endif
    xid31_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
